// File: rtl/line_reader_pkg.sv
// Shared word/line types for the LC-3b datapath and the cache, plus the
// line_reader FSM encoding.
package lc3b_types;
    typedef logic [15:0] lc3b_word;
endpackage : lc3b_types

package cache_types;
    import lc3b_types::*;

    localparam int CACHE_LINE_WORDS = 8;

    typedef logic [127:0] cache_line;
    typedef logic [2:0]   cache_read_offset;

    typedef enum logic [1:0] {
        LR_IDLE,
        LR_SINGLE,
        LR_BURST
    } line_reader_state_t;
endpackage : cache_types

// File: rtl/line_reader_word_select.sv
// Combinational 8:1 selection of one 16-bit word from a cache line.
// Word 0 occupies bits [15:0]; shared with the write-merge path.
module line_word_select
    import lc3b_types::*;
    import cache_types::*;
(
    input  cache_line        line,
    input  cache_read_offset offset,
    output lc3b_word         word
);

    always_comb begin
        word = line[{offset, 4'b0000} +: 16];
    end

endmodule : line_word_select

// File: rtl/line_reader.sv
// Captures a cache line and returns either one word or an 8-word
// critical-word-first wrapping burst over a valid/ready stream.
module line_reader
    import lc3b_types::*;
    import cache_types::*;
#(
    parameter int LINE_WORDS = CACHE_LINE_WORDS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_burst,
    input  logic [2:0]   req_offset,
    input  logic [127:0] req_line,
    output logic [15:0]  rdata,
    output logic         rdata_valid,
    output logic         rdata_last,
    input  logic         rdata_ready
);

    line_reader_state_t state_q, state_d;
    cache_line          line_q;
    cache_read_offset   idx_q;
    logic [2:0]         cnt_q;
    lc3b_word           word_sel;

    logic req_accept;
    logic beat_accept;

    assign req_accept  = req_valid && req_ready;
    assign beat_accept = rdata_valid && rdata_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the captured line is a plain register, not a memory, so it is
    // cleared on reset like the rest of the datapath state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_q <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
        end else if (req_accept) begin
            line_q <= req_line;
            idx_q  <= req_offset;
            cnt_q  <= '0;
        end else if (beat_accept && state_q == LR_BURST) begin
            idx_q <= idx_q + 3'd1;
            cnt_q <= cnt_q + 3'd1;
        end
    end

    // Control outputs depend on state only; inputs steer only the next state.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        rdata_valid = 1'b0;
        rdata_last  = 1'b0;
        unique case (state_q)
            LR_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = req_burst ? LR_BURST : LR_SINGLE;
                end
            end
            LR_SINGLE: begin
                rdata_valid = 1'b1;
                rdata_last  = 1'b1;
                if (rdata_ready) begin
                    state_d = LR_IDLE;
                end
            end
            LR_BURST: begin
                rdata_valid = 1'b1;
                rdata_last  = (cnt_q == 3'd7);
                if (rdata_ready && cnt_q == 3'd7) begin
                    state_d = LR_IDLE;
                end
            end
            default: begin
                state_d = LR_IDLE;
            end
        endcase
    end

    line_word_select u_word_select (
        .line   (line_q),
        .offset (idx_q),
        .word   (word_sel)
    );

    // Zero outside a beat keeps rdata at its reset value whenever idle.
    assign rdata = rdata_valid ? word_sel : 16'h0000;

    a_line_words : assert property (@(posedge clk) LINE_WORDS == CACHE_LINE_WORDS)
        else $error("line_reader: LINE_WORDS must be %0d", CACHE_LINE_WORDS);

endmodule : line_reader

// File: tb/tb_line_reader.sv
// Directed self-checking bench for line_reader: single reads, wrapping
// bursts, backpressure, capture isolation, mid-burst reset, back-to-back.
module tb_line_reader;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic         req_burst;
    logic [2:0]   req_offset;
    logic [127:0] req_line;
    logic [15:0]  rdata;
    logic         rdata_valid;
    logic         rdata_last;
    logic         rdata_ready;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] LINE_A = 128'h7766_5544_3322_1100_FFEE_DDCC_BBAA_9988;
    localparam logic [127:0] LINE_B = 128'h8888_7777_6666_5555_4444_3333_2222_1111;

    // Words of LINE_A, written out by hand (word0 first).
    logic [15:0] word_a [8] = '{16'h9988, 16'hBBAA, 16'hDDCC, 16'hFFEE,
                                16'h1100, 16'h3322, 16'h5544, 16'h7766};

    always #5 clk = ~clk;

    line_reader dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_burst   (req_burst),
        .req_offset  (req_offset),
        .req_line    (req_line),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .rdata_last  (rdata_last),
        .rdata_ready (rdata_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_burst   = 1'b0;
        req_offset  = 3'd0;
        req_line    = '0;
        rdata_ready = 1'b0;
        tick();
        tick();
        n_checks++;
        if (req_ready !== 1'b1 || rdata_valid !== 1'b0 || rdata_last !== 1'b0 || rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b valid=%b last=%b rdata=%h, expected 1 0 0 0000",
                     req_ready, rdata_valid, rdata_last, rdata);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        req_valid   = 1'b1;
        req_burst   = 1'b0;
        req_offset  = 3'd3;
        req_line    = LINE_A;
        rdata_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        n_checks++;
        if (rdata !== 16'hFFEE || rdata_valid !== 1'b1 || rdata_last !== 1'b1 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_beat: got rdata=%h valid=%b last=%b ready=%b, expected FFEE 1 1 0",
                     rdata, rdata_valid, rdata_last, req_ready);
        end
        tick();
        n_checks++;
        if (req_ready !== 1'b1 || rdata_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: got ready=%b valid=%b, expected 1 0", req_ready, rdata_valid);
        end
    endtask

    task automatic test_burst_wrap();
        logic [15:0] exp_b [8] = '{16'h3322, 16'h5544, 16'h7766, 16'h9988,
                                   16'hBBAA, 16'hDDCC, 16'hFFEE, 16'h1100};
        req_valid   = 1'b1;
        req_burst   = 1'b1;
        req_offset  = 3'd5;
        req_line    = LINE_A;
        rdata_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (rdata !== exp_b[i] || rdata_valid !== 1'b1 || rdata_last !== (i == 7)) begin
                n_fail++;
                $display("FAIL burst_beat%0d: got rdata=%h valid=%b last=%b, expected %h 1 %b",
                         i, rdata, rdata_valid, rdata_last, exp_b[i], (i == 7));
            end
            tick();
        end
        n_checks++;
        if (req_ready !== 1'b1 || rdata_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_idle: got ready=%b valid=%b, expected 1 0", req_ready, rdata_valid);
        end
    endtask

    task automatic test_backpressure();
        logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int   beat = 0;
        logic took;
        req_valid   = 1'b1;
        req_burst   = 1'b1;
        req_offset  = 3'd0;
        req_line    = LINE_A;
        rdata_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        for (int cyc = 0; cyc < 40 && beat < 8; cyc++) begin
            rdata_ready = pat[cyc % 4];
            n_checks++;
            if (rdata !== word_a[beat] || rdata_valid !== 1'b1 || rdata_last !== (beat == 7)) begin
                n_fail++;
                $display("FAIL bp_cycle%0d: got rdata=%h valid=%b last=%b, expected %h 1 %b",
                         cyc, rdata, rdata_valid, rdata_last, word_a[beat], (beat == 7));
            end
            took = rdata_ready;
            tick();
            if (took) beat++;
        end
        n_checks++;
        if (beat != 8 || rdata_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_complete: got beats=%0d valid=%b, expected 8 0", beat, rdata_valid);
        end
        rdata_ready = 1'b1;
    endtask

    task automatic test_capture_isolation();
        req_valid   = 1'b1;
        req_burst   = 1'b0;
        req_offset  = 3'd7;
        req_line    = LINE_A;
        rdata_ready = 1'b0;
        tick();
        req_line   = LINE_B;
        req_offset = 3'd0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (rdata !== 16'h7766 || rdata_valid !== 1'b1 || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got rdata=%h valid=%b ready=%b, expected 7766 1 0",
                         i, rdata, rdata_valid, req_ready);
            end
            tick();
        end
        rdata_ready = 1'b1;
        tick();
        n_checks++;
        if (req_ready !== 1'b1 || rdata_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_idle: got ready=%b valid=%b, expected 1 0", req_ready, rdata_valid);
        end
        tick();
        req_valid = 1'b0;
        n_checks++;
        if (rdata !== 16'h1111 || rdata_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL second_req: got rdata=%h valid=%b, expected 1111 1", rdata, rdata_valid);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        req_valid   = 1'b1;
        req_burst   = 1'b1;
        req_offset  = 3'd2;
        req_line    = LINE_A;
        rdata_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        n_checks++;
        if (rdata !== 16'h3322 || rdata_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_beat: got rdata=%h valid=%b, expected 3322 1", rdata, rdata_valid);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (rdata_valid !== 1'b0 || rdata !== 16'h0000 || req_ready !== 1'b1 || rdata_last !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got valid=%b rdata=%h ready=%b last=%b, expected 0 0000 1 0",
                     rdata_valid, rdata, req_ready, rdata_last);
        end
        #2;
        reset      = 1'b0;
        req_valid  = 1'b1;
        req_burst  = 1'b0;
        req_offset = 3'd1;
        tick();
        req_valid = 1'b0;
        n_checks++;
        if (rdata !== 16'hBBAA || rdata_valid !== 1'b1 || rdata_last !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset: got rdata=%h valid=%b last=%b, expected BBAA 1 1",
                     rdata, rdata_valid, rdata_last);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic        exp_rdy [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] exp_dat [5] = '{16'h0000, 16'h9988, 16'h0000, 16'h5544, 16'h0000};
        req_valid   = 1'b1;
        req_burst   = 1'b0;
        req_offset  = 3'd0;
        req_line    = LINE_A;
        rdata_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (req_ready !== exp_rdy[i] || rdata !== exp_dat[i] || rdata_valid !== !exp_rdy[i]) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: got ready=%b rdata=%h valid=%b, expected %b %h %b",
                         i, req_ready, rdata, rdata_valid, exp_rdy[i], exp_dat[i], !exp_rdy[i]);
            end
            if (i == 1) req_offset = 3'd6;
            if (i == 3) req_valid = 1'b0;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst_wrap();
        test_backpressure();
        test_capture_isolation();
        test_reset_mid_burst();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_line_reader

// File: doc/line_reader.md
Name: line_reader

Overview:
Read-side counterpart of the cache write-merge path. It captures a 128-bit cache line and returns 16-bit words from it over a valid/ready stream.
- Single mode returns the one word at the requested offset.
- Burst mode streams all 8 words critical-word-first, wrapping from the requested offset. Used for serving CPU reads and for serialising dirty lines on write-back.
- Sits between the cache data array and the datapath / physical-memory write-back port.

Parameters:
LINE_WORDS, 8, words per cache line. Fixed by cache_line / lc3b_word; present for assertions only. Any other value is illegal.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_burst  in  1  0 = single word, 1 = 8-word wrapping burst
req_offset  in  3  cache_read_offset; word index of the first/only word
req_line  in  128  cache_line to read from
rdata  out  16  lc3b_word; current output word
rdata_valid  out  1  rdata holds a valid beat
rdata_last  out  1  current beat is the final beat of the transaction
rdata_ready  in  1  consumer accepts the beat

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values: state = IDLE, req_ready = 1, rdata_valid = 0, rdata_last = 0, rdata = 16'h0000. Internal line_q, idx_q and cnt_q are all cleared to 0.
- Handshakes:
  - Request accepted when req_valid && req_ready.
  - Beat accepted when rdata_valid && rdata_ready.
- FSM states: IDLE, SINGLE, BURST.
- IDLE:
  - req_ready = 1; rdata_valid = 0.
  - On accept: line_q <= req_line, idx_q <= req_offset, cnt_q <= 0.
  - Next state is SINGLE if req_burst = 0, else BURST.
- SINGLE:
  - req_ready = 0, rdata_valid = 1, rdata_last = 1.
  - rdata = line_q word idx_q, i.e. bits [16*idx_q+15 : 16*idx_q]. Word 0 is bits [15:0]; bytes are little-endian within a word.
  - Beat accepted -> IDLE.
  - rdata_ready low -> hold rdata, rdata_valid and rdata_last stable; no timeout.
- BURST:
  - req_ready = 0, rdata_valid = 1, rdata = line_q word idx_q, rdata_last = (cnt_q == 7).
  - On beat accepted: idx_q <= idx_q + 1 (3-bit wrap, 7 -> 0) and cnt_q <= cnt_q + 1.
  - Beat accepted while cnt_q == 7 -> IDLE.
  - Exactly 8 beats per burst, each word delivered exactly once.
- Latency: first beat is valid the cycle after request accept. No bubbles inside a burst while rdata_ready = 1.
- Turnaround: one idle cycle (req_ready = 1, rdata_valid = 0) after every transaction. A req_valid held during a busy cycle is not accepted; it is taken in the IDLE cycle.
- Output stability: all outputs are derived from registered state only (no combinational path from any input to any output). Outputs do not change while rdata_valid && !rdata_ready.
- Capture isolation: req_line, req_offset and req_burst changes after accept have no effect on the transaction in flight.
- Reset mid-transaction: return immediately to IDLE with reset values. The partial burst is discarded and not resumed.
- rdata_ready asserted while rdata_valid = 0: ignored.

Decomposition:
- Use cache_line, cache_read_offset and lc3b_word from the existing cache_types / lc3b_types packages.
- Add to cache_types: enum line_reader_state_t {LR_IDLE, LR_SINGLE, LR_BURST} and the constant CACHE_LINE_WORDS = 8.
- One natural sub-module: line_word_select. It is a combinational 8:1 mux of 16-bit words indexed by cache_read_offset, reusable by the write-merge path.

Test Plan:
Common stimulus line: req_line = 128'h7766_5544_3322_1100_FFEE_DDCC_BBAA_9988 (word0 = 9988 ... word7 = 7766).
1. Single, offset 3, rdata_ready = 1 -> next cycle rdata = FFEE, rdata_valid = 1, rdata_last = 1. Following cycle IDLE, req_ready = 1.
2. Burst, offset 5, rdata_ready = 1 -> 8 consecutive beats 3322, 5544, 7766, 9988, BBAA, DDCC, FFEE, 1100. rdata_last is high only on 1100.
3. Burst, offset 0, rdata_ready toggled 1,0,0,1,... -> beats in order 9988..7766 with none skipped or duplicated. Outputs stay stable while ready = 0.
4. Single, offset 7, rdata_ready = 0 for 5 cycles; req_line changed and req_valid held high meanwhile -> rdata stays 7766 and req_ready stays 0. Second request is accepted only in the IDLE cycle after the beat is taken.
5. Burst, offset 2; assert reset after the 3rd beat -> same cycle: rdata_valid = 0, rdata = 0000, req_ready = 1. A new single request at offset 1 then returns BBAA.
6. Back-to-back single requests at offsets 0 and 6 with req_valid held high -> 9988, idle cycle, 5544; req_ready pattern 1,0,1,0,1.
